// File: rtl/l1_req_queue.sv
// l1_req_queue: per-core FIFO of opaque request codes feeding an L1 request port.
// Ready/valid on both sides. The head request, out_valid and almost_full are
// all registered from next-state values, so no input reaches an output
// combinationally except in_ready. Saturating stall and issue counters are
// kept for latency debug.
module l1_req_queue #(
  parameter int DEPTH = 4,
  parameter int REQ_W = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic [REQ_W-1:0]           in_req,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [REQ_W-1:0]           out_req,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       almost_full,
  output logic [CNT_W-1:0]           stall_cycles,
  output logic [CNT_W-1:0]           issued_count
);

  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [REQ_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_next, wr_next;
  logic [OCC_W-1:0] occ_next, occ_after_pop;
  logic [REQ_W-1:0] head_next;
  logic             push, pop;

  // Accept only when space exists, outside flush and reset; never looks at out_ready.
  assign in_ready = (occupancy < OCC_W'(DEPTH)) && !flush && reset_n;

  // Next-state bookkeeping; flush overrides the push/pop pointer and occupancy updates.
  always_comb begin
    push          = in_valid && in_ready;
    pop           = out_valid && out_ready;
    occ_after_pop = occupancy - OCC_W'(pop);
    occ_next      = occupancy + OCC_W'(push) - OCC_W'(pop);
    rd_next       = rd_ptr + PTR_W'(pop);
    wr_next       = wr_ptr + PTR_W'(push);
    if (flush) begin
      occ_next = '0;
      rd_next  = '0;
      wr_next  = '0;
    end
    // The next head is the pushed word only if the queue drains to empty
    // underneath it; otherwise it already sits in the array.
    if (occ_next == '0)           head_next = '0;
    else if (occ_after_pop == '0) head_next = in_req;
    else                          head_next = mem[rd_next];
  end

  // Storage array; contents need no reset because occupancy qualifies them.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_req;
  end

  // Pointers, occupancy and the registered head/flags.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      occupancy   <= '0;
      out_valid   <= 1'b0;
      out_req     <= '0;
      almost_full <= 1'b0;
    end else begin
      rd_ptr      <= rd_next;
      wr_ptr      <= wr_next;
      occupancy   <= occ_next;
      out_valid   <= (occ_next != '0);
      out_req     <= head_next;
      almost_full <= (occ_next >= OCC_W'(DEPTH-1));
    end
  end

  // Saturating debug counters; flush leaves them alone, and a pop in the flush
  // cycle still counts because L1 has taken that request.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stall_cycles <= '0;
      issued_count <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (pop && (issued_count != '1))
        issued_count <= issued_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_l1_req_queue.sv
// tb_l1_req_queue: directed then random stimulus against a queue-based model.
// A second instance with 4-bit counters shares the inputs to exercise saturation.
module tb_l1_req_queue;

  localparam int DEPTH = 4;
  localparam int REQ_W = 4;

  logic             clock = 1'b0;
  logic             reset_n, flush, in_valid, out_ready;
  logic [REQ_W-1:0] in_req;

  logic             in_ready, out_valid, almost_full;
  logic [REQ_W-1:0] out_req;
  logic [2:0]       occupancy;
  logic [15:0]      stall_cycles, issued_count;

  logic             in_ready4, out_valid4, almost_full4;
  logic [REQ_W-1:0] out_req4;
  logic [2:0]       occupancy4;
  logic [3:0]       stall_cycles4, issued_count4;

  int total = 0;
  int bad   = 0;

  // model state
  int mq[$];
  int m_stall, m_issued, m_stall4, m_issued4;

  always #5 clock = ~clock;

  l1_req_queue #(.DEPTH(DEPTH), .REQ_W(REQ_W), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_req(in_req), .in_valid(in_valid), .in_ready(in_ready),
    .out_req(out_req), .out_valid(out_valid), .out_ready(out_ready),
    .occupancy(occupancy), .almost_full(almost_full),
    .stall_cycles(stall_cycles), .issued_count(issued_count)
  );

  l1_req_queue #(.DEPTH(DEPTH), .REQ_W(REQ_W), .CNT_W(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_req(in_req), .in_valid(in_valid), .in_ready(in_ready4),
    .out_req(out_req4), .out_valid(out_valid4), .out_ready(out_ready),
    .occupancy(occupancy4), .almost_full(almost_full4),
    .stall_cycles(stall_cycles4), .issued_count(issued_count4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, check in_ready, advance model at the edge, check outputs.
  task automatic step(input logic iv, input logic [REQ_W-1:0] rq, input logic ordy,
                      input logic fl, input logic rn);
    logic exp_rdy, m_vld, pop, push;
    in_valid = iv; in_req = rq; out_ready = ordy; flush = fl; reset_n = rn;
    #1;
    exp_rdy = rn && !fl && (mq.size() < DEPTH);
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    @(posedge clock);
    if (!rn) begin
      mq.delete();
      m_stall = 0; m_issued = 0; m_stall4 = 0; m_issued4 = 0;
    end else begin
      m_vld = (mq.size() != 0);
      pop   = m_vld && ordy;
      push  = iv && exp_rdy;
      if (m_vld && !ordy) begin
        if (m_stall  < 65535) m_stall++;
        if (m_stall4 < 15)    m_stall4++;
      end
      if (pop) begin
        if (m_issued  < 65535) m_issued++;
        if (m_issued4 < 15)    m_issued4++;
      end
      if (fl) mq.delete();
      else begin
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(int'(rq));
      end
    end
    #1;
    chk("occupancy",   32'(occupancy),   32'(mq.size()));
    chk("out_valid",   {31'd0, out_valid},   {31'd0, mq.size() != 0});
    chk("almost_full", {31'd0, almost_full}, {31'd0, mq.size() >= DEPTH-1});
    if (mq.size() != 0) chk("out_req", 32'(out_req), 32'(mq[0]));
    chk("stall_cycles",  32'(stall_cycles),  32'(m_stall));
    chk("issued_count",  32'(issued_count),  32'(m_issued));
    chk("stall_cycles4", 32'(stall_cycles4), 32'(m_stall4));
    chk("issued_count4", 32'(issued_count4), 32'(m_issued4));
  endtask

  initial begin
    m_stall = 0; m_issued = 0; m_stall4 = 0; m_issued4 = 0;
    in_valid = 0; in_req = '0; out_ready = 0; flush = 0; reset_n = 0;

    // reset state
    step(0, 4'h0, 0, 0, 0);
    step(1, 4'hA, 1, 0, 0);
    chk("rst_out_req",   32'(out_req),   32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_occ",       32'(occupancy), 32'd0);

    // push 3,5,9 held, then drain in order
    step(1, 4'd3, 0, 0, 1);
    step(1, 4'd5, 0, 0, 1);
    step(1, 4'd9, 0, 0, 1);
    chk("order_head0", 32'(out_req), 32'd3);
    step(0, 4'd0, 1, 0, 1);
    chk("order_head1", 32'(out_req), 32'd5);
    step(0, 4'd0, 1, 0, 1);
    chk("order_head2", 32'(out_req), 32'd9);
    step(0, 4'd0, 1, 0, 1);
    chk("order_empty", 32'(out_valid), 32'd0);
    chk("issued_3",    32'(issued_count), 32'd3);

    // fill to full, 5th push refused
    for (int i = 0; i < 4; i++) step(1, 4'(i + 1), 0, 0, 1);
    chk("full_occ", 32'(occupancy),   32'd4);
    chk("full_af",  32'(almost_full), 32'd1);
    step(1, 4'hF, 0, 0, 1);
    chk("no_push_full", 32'(occupancy), 32'd4);

    // full, pop and push same cycle: only pop happens; push lands next cycle
    step(1, 4'hE, 1, 0, 1);
    chk("full_pop_occ", 32'(occupancy), 32'd3);
    step(1, 4'hE, 0, 0, 1);
    chk("push_after", 32'(occupancy), 32'd4);

    // drain, then single push into empty queue, then streaming
    for (int i = 0; i < 4; i++) step(0, 4'd0, 1, 0, 1);
    step(1, 4'd7, 1, 0, 1);
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_req",   32'(out_req),   32'd7);
    for (int i = 0; i < 6; i++) step(1, 4'(i + 8), 1, 0, 1);
    chk("stream_occ", 32'(occupancy), 32'd1);
    chk("stream_req", 32'(out_req),   32'd13);

    // stall count with 2 entries, then flush
    step(0, 4'd0, 0, 0, 0);
    step(1, 4'd1, 0, 0, 1);
    step(1, 4'd2, 0, 0, 1);
    for (int i = 0; i < 9; i++) step(0, 4'd0, 0, 0, 1);
    chk("stall_10", 32'(stall_cycles), 32'd10);
    chk("stall_occ", 32'(occupancy), 32'd2);
    step(1, 4'd4, 1, 1, 1);
    chk("flush_occ",   32'(occupancy),    32'd0);
    chk("flush_valid", 32'(out_valid),    32'd0);
    chk("flush_stall", 32'(stall_cycles), 32'd10);
    chk("flush_issue", 32'(issued_count), 32'd1);

    // 20 pops: 4-bit counter saturates
    step(0, 4'd0, 0, 0, 0);
    for (int i = 0; i < 21; i++) step(1, 4'(i), 1, 0, 1);
    chk("sat_issued4", 32'(issued_count4), 32'd15);
    chk("sat_issued",  32'(issued_count),  32'd20);
    step(0, 4'd0, 1, 0, 0);
    chk("rst2_issued", 32'(issued_count), 32'd0);
    chk("rst2_occ",    32'(occupancy),    32'd0);
    chk("rst2_valid",  32'(out_valid),    32'd0);

    // random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 99) < 60), 4'($urandom), 1'($urandom_range(0, 99) < 50),
           1'($urandom_range(0, 99) < 4), 1'($urandom_range(0, 99) >= 2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
